cache_req_arbiter: RTL

//  Two-requester arbiter sharing one blocking cache_Cache processor port (e.g. proc
//  I/D or proc + Blastn engine). Muxes mem_req_16B_t requests round-robin into the

---
 rtl/cache_req_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cache_req_arbiter.sv
// Two-requester arbiter in front of one blocking, in-order cache processor port.
// Define CACHE_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.

package cache_msgs_pkg;
  typedef struct packed {
    logic [2:0]   typ;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   typ;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

  localparam int REQ_W  = $bits(mem_req_16B_t);
  localparam int RESP_W = $bits(mem_resp_16B_t);
endpackage

module cache_req_arbiter
  import cache_msgs_pkg::*;
#(
  parameter int NUM_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REQ_W-1:0]  req0_reqstream_msg,
  input  logic              req0_reqstream_val,
  output logic              req0_reqstream_rdy,
  output logic [RESP_W-1:0] req0_respstream_msg,
  output logic              req0_respstream_val,
  input  logic              req0_respstream_rdy,
  input  logic [REQ_W-1:0]  req1_reqstream_msg,
  input  logic              req1_reqstream_val,
  output logic              req1_reqstream_rdy,
  output logic [RESP_W-1:0] req1_respstream_msg,
  output logic              req1_respstream_val,
  input  logic              req1_respstream_rdy,
  output logic [REQ_W-1:0]  cache_reqstream_msg,
  output logic              cache_reqstream_val,
  input  logic              cache_reqstream_rdy,
  input  logic [RESP_W-1:0] cache_respstream_msg,
  input  logic              cache_respstream_val,
  output logic              cache_respstream_rdy
);

  localparam int CntW = $clog2(NUM_OUTSTANDING + 1);
  localparam int PtrW = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;

  logic [NUM_OUTSTANDING-1:0] r_ownerFifo;
  logic [PtrW-1:0]            r_wrPtr;
  logic [PtrW-1:0]            r_rdPtr;
  logic [CntW-1:0]            r_count;
  logic                       r_holdVld;
  logic                       r_holdId;
`ifndef CACHE_ARB_FIXED_PRIO_EN
  logic                       r_lastGrant;
`endif

  logic w_grant;
  logic w_full;
  logic w_empty;
  logic w_owner;
  logic w_reqFire;
  logic w_respFire;
  logic w_resp0Val;
  logic w_resp1Val;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(NUM_OUTSTANDING - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_full  = (r_count == CntW'(NUM_OUTSTANDING));
  assign w_empty = (r_count == '0);
  assign w_owner = r_ownerFifo[r_rdPtr];

  // A stalled request keeps its grant so the cache sees a stable message.
  always_comb begin
    w_grant = 1'b0;
    if (r_holdVld) begin
      w_grant = r_holdId;
    end else if (req0_reqstream_val && req1_reqstream_val) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
      w_grant = 1'b0;
`else
      w_grant = ~r_lastGrant;
`endif
    end else if (req1_reqstream_val) begin
      w_grant = 1'b1;
    end
  end

  assign cache_reqstream_val = ~reset & (req0_reqstream_val | req1_reqstream_val) & ~w_full;
  assign req0_reqstream_rdy  = ~reset & cache_reqstream_rdy & ~w_full & ~w_grant;
  assign req1_reqstream_rdy  = ~reset & cache_reqstream_rdy & ~w_full & w_grant;
  assign cache_reqstream_msg = (w_grant ? req1_reqstream_msg : req0_reqstream_msg)
                               & {REQ_W{cache_reqstream_val}};
  assign w_reqFire           = cache_reqstream_val & cache_reqstream_rdy;

  assign w_resp0Val           = ~reset & cache_respstream_val & ~w_empty & ~w_owner;
  assign w_resp1Val           = ~reset & cache_respstream_val & ~w_empty & w_owner;
  assign req0_respstream_val  = w_resp0Val;
  assign req1_respstream_val  = w_resp1Val;
  assign req0_respstream_msg  = cache_respstream_msg & {RESP_W{w_resp0Val}};
  assign req1_respstream_msg  = cache_respstream_msg & {RESP_W{w_resp1Val}};
  assign cache_respstream_rdy = ~reset & ~w_empty
                                & (w_owner ? req1_respstream_rdy : req0_respstream_rdy);
  assign w_respFire           = cache_respstream_val & cache_respstream_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ownerFifo <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_holdVld   <= 1'b0;
      r_holdId    <= 1'b0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
      r_lastGrant <= 1'b1;
`endif
    end else begin
      if (w_reqFire) begin
        r_ownerFifo[r_wrPtr] <= w_grant;
        r_wrPtr              <= nextPtr(r_wrPtr);
        r_holdVld            <= 1'b0;
`ifndef CACHE_ARB_FIXED_PRIO_EN
        r_lastGrant          <= w_grant;
`endif
      end else if (cache_reqstream_val) begin
        r_holdVld <= 1'b1;
        r_holdId  <= w_grant;
      end
      if (w_respFire) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      // Push and pop together leave the occupancy unchanged.
      if (w_reqFire && !w_respFire) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_reqFire && w_respFire) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && cache_respstream_val && w_empty) begin
      $error("cache_req_arbiter: response arrived with no request outstanding");
    end
  end
`endif

endmodule
